// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multicycle MIPS-style datapath. The instruction is fetched
// from memory, decoded, and then stepped through its execution states.
// Memory accesses wait for mem_ready. A wait counter faults the FSM into ERR
// when one access stalls too long.
//
// Parameters
//   TIMEOUT      max cycles one memory access may wait (1..15)
//
// Inputs
//   clk          rising-edge clock
//   clr_n        asynchronous active-low reset
//   opcode       instruction bits [31:26]
//   funct        instruction bits [5:0]
//   zero         ALU zero flag (branch condition)
//   mem_ready    memory access completes this cycle
//
// Outputs
//   mem_req, i_or_d, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
//   alu_src_a, pc_en          datapath controls
//   alu_src_b[1:0]            00=RD2, 01=4, 10=SignImm, 11=SignImm<<2
//   pc_src[1:0]               00=ALU result, 01=ALUOut, 10=jump target
//   alu_control[2:0]          ALU operation
//   err                       sticky fault flag (state ERR)
//   state[3:0]                current state, for debug
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic       pc_en,
    output logic       err,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_ERR    = 4'd15
    } state_e;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Count value at which a still-stalled access gives up.
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       timed_out;
    logic       in_wait_state;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign timed_out     = (wait_q == WAIT_LAST);
    assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                           (state_q == S_MEMWR);

    // NOTE: every output and next-state signal gets a default before the case
    // so no path through this block can infer a latch.
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        i_or_d      = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        pc_en       = 1'b0;
        err         = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        alu_control = ALU_ADD;

        unique case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ERR;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready)      state_d = S_MEMWB;
                else if (timed_out) state_d = S_ERR;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                mem_write = mem_ready;
                if (mem_ready)      state_d = S_FETCH;
                else if (timed_out) state_d = S_ERR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_ALUWB;
                case (funct)
                    6'b100000: alu_control = ALU_ADD;
                    6'b100010: alu_control = ALU_SUB;
                    6'b100100: alu_control = ALU_AND;
                    6'b100101: alu_control = ALU_OR;
                    6'b101010: alu_control = ALU_SLT;
                    default:   state_d     = S_ERR;
                endcase
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_en       = zero;
                state_d     = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            S_ERR: begin
                alu_control = 3'b000;
                err         = 1'b1;
            end
            // Unused codes 12..14 fall straight into the fault state.
            default: state_d = S_ERR;
        endcase

        // While reset is held the FSM sits in FETCH; suppress the side-effect
        // strobes so nothing is requested or written.
        if (!clr_n) begin
            mem_req   = 1'b0;
            ir_write  = 1'b0;
            pc_en     = 1'b0;
            mem_write = 1'b0;
        end
    end

    // Counter restarts whenever the FSM enters a new state and advances only
    // while a memory access is stalled.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (in_wait_state && !mem_ready) begin
            wait_d = wait_q + 4'd1;
        end
    end

    assign state = state_q;

endmodule
